// File: rtl/fetch_prefetch_unit_if.sv
// rtl/fetch_prefetch_unit_if.sv - instruction-memory, redirect and IF/ID bundle for the fetch unit
interface fetch_prefetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [DATA_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  redirect;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  inst_ready;
    logic                  inst_valid;
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] inst_pc_plus4;
    logic [15:0]           redirect_count;

    // fetch unit side
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc_plus4, redirect_count,
        input  imem_ack, imem_data, redirect, redirect_pc, inst_ready
    );

    // memory / pipeline side
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc_plus4, redirect_count,
        output imem_ack, imem_data, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - credit-based instruction prefetcher with redirect flush
module fetch_prefetch_unit #(
    parameter int                DATA_WIDTH = 32,
    parameter int                DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = '0,
    parameter int                PC_INCR    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_prefetch_unit_if.master  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  req_q, req_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         count_q;
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [15:0]           redir_cnt_q;

    logic [DATA_WIDTH-1:0] fifo_inst_q [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc4_q  [DEPTH];

    logic                  push, pop, credit;
    logic [CW-1:0]         count_after;
    logic [DATA_WIDTH-1:0] addr_incr;

    assign addr_incr = addr_q + DATA_WIDTH'(PC_INCR);

    // a redirect cycle never pushes or pops; the flush wins
    assign push = (state_q == S_REQ) && bus.imem_ack && !bus.redirect;
    assign pop  = (count_q != '0) && bus.inst_ready && !bus.redirect;

    // occupancy after this edge decides whether another fetch may be issued
    always_comb begin
        count_after = '0;
        if (!bus.redirect) begin
            count_after = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
        end
    end

    assign credit = (count_after < DEPTH_C);

    // fetch sequencing: issue, back-to-back continue, or drain a stale request
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        case (state_q)
            S_IDLE: begin
                if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                end else if (credit) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.imem_ack && !bus.redirect) begin
                    fetch_pc_d = addr_incr;
                    if (credit) begin
                        addr_d = addr_incr;
                    end else begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (bus.imem_ack) begin
                    fetch_pc_d = bus.redirect_pc;
                    req_d      = 1'b0;
                    state_d    = S_IDLE;
                end else if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                    state_d    = S_DROP;
                end
            end
            S_DROP: begin
                if (bus.imem_ack) begin
                    // FIFO was flushed on entry, so the follow-up fetch always has credit
                    addr_d     = bus.redirect ? bus.redirect_pc : fetch_pc_q;
                    fetch_pc_d = bus.redirect ? bus.redirect_pc : fetch_pc_q;
                    state_d    = S_REQ;
                end else if (bus.redirect) begin
                    fetch_pc_d = bus.redirect_pc;
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // fetch state and registered memory request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else if (bus.redirect) begin
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q <= count_after;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while the entry is not counted
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wr_ptr_q] <= bus.imem_data;
            fifo_pc4_q[wr_ptr_q]  <= addr_incr;
        end
    end

    // saturating count of redirect cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redir_cnt_q <= '0;
        end else if (bus.redirect && (redir_cnt_q != 16'hFFFF)) begin
            redir_cnt_q <= redir_cnt_q + 16'd1;
        end
    end

    assign bus.imem_req       = req_q;
    assign bus.imem_addr      = addr_q;
    assign bus.inst_valid     = (count_q != '0);
    assign bus.inst           = (count_q != '0) ? fifo_inst_q[rd_ptr_q] : '0;
    assign bus.inst_pc_plus4  = (count_q != '0) ? fifo_pc4_q[rd_ptr_q]  : '0;
    assign bus.redirect_count = redir_cnt_q;

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == DEPTH_C)));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - directed checks of fetch_prefetch_unit
module tb_fetch_prefetch_unit;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    int   lat;
    int   wait_cnt;

    fetch_prefetch_unit_if #(.DATA_WIDTH(32)) bus ();

    fetch_prefetch_unit #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0),
        .PC_INCR    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: ack after lat idle cycles of imem_req, data is ~addr
    always @(negedge clk) begin
        if (reset || !bus.imem_req) begin
            bus.imem_ack = 1'b0;
            wait_cnt     = 0;
        end else if (wait_cnt >= lat) begin
            bus.imem_ack  = 1'b1;
            bus.imem_data = ~bus.imem_addr;
            wait_cnt      = 0;
        end else begin
            bus.imem_ack = 1'b0;
            wait_cnt     = wait_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_pass = 0;
        lat = 0;
        wait_cnt = 0;
        reset = 1'b1;
        bus.imem_ack = 1'b0;
        bus.imem_data = '0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready = 1'b1;

        // reset values
        step();
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst_inst", bus.inst, 32'h0);
        chk("rst_pc4", bus.inst_pc_plus4, 32'h0);
        chk("rst_rcnt", 32'(bus.redirect_count), 32'd0);
        step();
        reset = 1'b0;

        // sequential streaming with 1-cycle ack, no bubbles
        for (int i = 0; i < 10 && !bus.inst_valid; i++) step();
        chk("seq_first_valid", 32'(bus.inst_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("seq_valid", 32'(bus.inst_valid), 32'd1);
            chk("seq_pc4", bus.inst_pc_plus4, 32'(4 * (i + 1)));
            chk("seq_inst", bus.inst, ~32'(4 * i));
            chk("seq_addr", bus.imem_addr, 32'(4 * (i + 1)));
            step();
        end

        // stalled consumer fills exactly DEPTH entries then stops fetching
        bus.inst_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 7; i++) step();
        chk("full_req", 32'(bus.imem_req), 32'd0);
        chk("full_valid", 32'(bus.inst_valid), 32'd1);
        chk("full_head_pc4", bus.inst_pc_plus4, 32'h4);
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc4", bus.inst_pc_plus4, 32'(4 * (i + 1)));
            chk("drain_inst", bus.inst, ~32'(4 * i));
            step();
            if (i == 0) begin
                chk("resume_req", 32'(bus.imem_req), 32'd1);
                chk("resume_addr", bus.imem_addr, 32'h10);
            end
        end
        chk("resume_head_pc4", bus.inst_pc_plus4, 32'h14);

        // redirect while a slow fetch of 0x8 is pending
        lat = 3;
        do_reset();
        for (int i = 0; i < 40 && !(bus.imem_req && bus.imem_addr == 32'h8); i++) step();
        chk("drop_wait_addr8", bus.imem_addr, 32'h8);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect = 1'b0;
        chk("drop_flush_valid", 32'(bus.inst_valid), 32'd0);
        chk("drop_req_held", 32'(bus.imem_req), 32'd1);
        chk("drop_addr_held", bus.imem_addr, 32'h8);
        for (int i = 0; i < 20 && bus.imem_addr != 32'h100; i++) step();
        chk("drop_new_addr", bus.imem_addr, 32'h100);
        chk("drop_no_stale_push", 32'(bus.inst_valid), 32'd0);
        for (int i = 0; i < 20 && !bus.inst_valid; i++) step();
        chk("drop_first_pc4", bus.inst_pc_plus4, 32'h104);
        chk("drop_first_inst", bus.inst, ~32'h100);
        chk("drop_rcnt", 32'(bus.redirect_count), 32'd1);

        // redirect coinciding with ack and inst_ready
        lat = 0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk("coin_pre_valid", 32'(bus.inst_valid), 32'd1);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
        step();
        bus.redirect = 1'b0;
        chk("coin_valid", 32'(bus.inst_valid), 32'd0);
        chk("coin_req", 32'(bus.imem_req), 32'd0);
        step();
        chk("coin_issue_req", 32'(bus.imem_req), 32'd1);
        chk("coin_issue_addr", bus.imem_addr, 32'h200);
        step();
        chk("coin_pc4", bus.inst_pc_plus4, 32'h204);
        chk("coin_inst", bus.inst, ~32'h200);
        chk("coin_rcnt", 32'(bus.redirect_count), 32'd1);

        // address wrap at the top of the address space
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        step();
        bus.redirect = 1'b0;
        step();
        chk("wrap_issue_addr", bus.imem_addr, 32'hFFFF_FFF8);
        step();
        chk("wrap_pc4_0", bus.inst_pc_plus4, 32'hFFFF_FFFC);
        chk("wrap_addr_1", bus.imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc4_1", bus.inst_pc_plus4, 32'h0);
        chk("wrap_inst_1", bus.inst, ~32'hFFFF_FFFC);
        step();
        chk("wrap_pc4_2", bus.inst_pc_plus4, 32'h4);
        chk("wrap_rcnt", 32'(bus.redirect_count), 32'd2);

        // asynchronous reset in the middle of DROP
        lat = 5;
        do_reset();
        step();
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h300;
        step();
        bus.redirect = 1'b0;
        chk("mid_drop_req", 32'(bus.imem_req), 32'd1);
        chk("mid_drop_addr", bus.imem_addr, 32'h0);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_req", 32'(bus.imem_req), 32'd0);
        chk("async_rst_addr", bus.imem_addr, 32'h0);
        chk("async_rst_valid", 32'(bus.inst_valid), 32'd0);
        chk("async_rst_pc4", bus.inst_pc_plus4, 32'h0);
        chk("async_rst_rcnt", 32'(bus.redirect_count), 32'd0);
        lat = 0;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_req", 32'(bus.imem_req), 32'd1);
        chk("post_rst_addr", bus.imem_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
